// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared FSM state, key code constants and key encoding for the keypad scanner
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        REPORT,
        RELEASE
    } keypad_state_e;

    localparam logic [3:0] KEY_0    = 4'b0000;
    localparam logic [3:0] KEY_1    = 4'b0001;
    localparam logic [3:0] KEY_2    = 4'b0010;
    localparam logic [3:0] KEY_3    = 4'b0011;
    localparam logic [3:0] KEY_4    = 4'b0100;
    localparam logic [3:0] KEY_5    = 4'b0101;
    localparam logic [3:0] KEY_6    = 4'b0110;
    localparam logic [3:0] KEY_7    = 4'b0111;
    localparam logic [3:0] KEY_8    = 4'b1000;
    localparam logic [3:0] KEY_9    = 4'b1001;
    localparam logic [3:0] KEY_STAR = 4'b1010;
    localparam logic [3:0] KEY_HASH = 4'b1011;
    localparam logic [3:0] KEY_ERR  = 4'b1111;

    // Telephone layout for the standard 4x3 pad; other geometries fall back to the raw index.
    function automatic logic [3:0] idx_to_code(input int row, input int col,
                                               input int rows, input int cols);
        int idx;
        idx = row * cols + col;
        if (rows == 4 && cols == 3) begin
            case (idx)
                0:       idx_to_code = KEY_1;
                1:       idx_to_code = KEY_2;
                2:       idx_to_code = KEY_3;
                3:       idx_to_code = KEY_4;
                4:       idx_to_code = KEY_5;
                5:       idx_to_code = KEY_6;
                6:       idx_to_code = KEY_7;
                7:       idx_to_code = KEY_8;
                8:       idx_to_code = KEY_9;
                9:       idx_to_code = KEY_STAR;
                10:      idx_to_code = KEY_0;
                11:      idx_to_code = KEY_HASH;
                default: idx_to_code = KEY_ERR;
            endcase
        end else if (idx < 12) begin
            idx_to_code = 4'(idx);
        end else begin
            idx_to_code = KEY_ERR;
        end
    endfunction

endpackage

// File: rtl/keypad_row_sync.sv
// rtl/keypad_row_sync.sv - two-flop synchroniser for the asynchronous row sense lines
module keypad_row_sync #(
    parameter int ROWS = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [ROWS-1:0] row_in,
    output logic [ROWS-1:0] row_sync
);

    logic [ROWS-1:0] meta_q, meta_d;
    logic [ROWS-1:0] sync_q, sync_d;

    always_comb begin
        meta_d = row_in;
        sync_d = meta_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign row_sync = sync_q;

endmodule

// File: rtl/keypad_scan_ctrl.sv
// rtl/keypad_scan_ctrl.sv - matrix keypad scanner: column strobe, debounce, one report per press
module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter int ROWS            = 4,
    parameter int COLS            = 3,
    parameter int SETTLE_CYCLES   = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int IDX_W           = 6
) (
    input  logic             stimulus,
    input  logic             reset,
    input  logic [ROWS-1:0]  row_in,
    output logic [COLS-1:0]  col_drive,
    output logic             key_valid,
    input  logic             key_ready,
    output logic [IDX_W-1:0] key_index,
    output logic [3:0]       key_code,
    output logic             key_err
);

    localparam int CW = $clog2(COLS);
    localparam int RW = $clog2(ROWS);
    localparam int SW = $clog2(SETTLE_CYCLES);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [CW-1:0] COL_LAST    = CW'(COLS - 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [DW-1:0] DEB_LAST    = DW'(DEBOUNCE_CYCLES - 1);

    logic [ROWS-1:0] rs;

    keypad_row_sync #(.ROWS(ROWS)) u_row_sync (
        .clk      (stimulus),
        .reset    (reset),
        .row_in   (row_in),
        .row_sync (rs)
    );

    keypad_state_e    state_q, state_d;
    logic [CW-1:0]    col_q, col_d;
    logic [SW-1:0]    set_cnt_q, set_cnt_d;
    logic [DW-1:0]    deb_cnt_q, deb_cnt_d;
    logic [ROWS-1:0]  pat_q, pat_d;
    logic             key_valid_q, key_valid_d;
    logic [IDX_W-1:0] key_index_q, key_index_d;
    logic [3:0]       key_code_q, key_code_d;
    logic             key_err_q, key_err_d;

    logic [RW-1:0]    row_lo;
    logic [CW-1:0]    col_next;
    logic [IDX_W-1:0] rep_index;
    logic [3:0]       rep_code;
    logic             rep_err;

    // Report contents derived from the latched pattern; a multi-row pattern reports its lowest row.
    always_comb begin
        row_lo = '0;
        for (int r = ROWS - 1; r >= 0; r--) begin
            if (pat_q[r]) row_lo = RW'(r);
        end
        if ($countones(pat_q) == 1) begin
            rep_index = IDX_W'(int'(row_lo) * COLS + int'(col_q));
            rep_code  = idx_to_code(int'(row_lo), int'(col_q), ROWS, COLS);
            rep_err   = 1'b0;
        end else begin
            rep_index = IDX_W'(row_lo);
            rep_code  = KEY_ERR;
            rep_err   = 1'b1;
        end
        col_next = (col_q == COL_LAST) ? '0 : col_q + 1'b1;
    end

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        set_cnt_d   = set_cnt_q;
        deb_cnt_d   = deb_cnt_q;
        pat_d       = pat_q;
        key_valid_d = key_valid_q;
        key_index_d = key_index_q;
        key_code_d  = key_code_q;
        key_err_d   = key_err_q;

        case (state_q)
            SCAN: begin
                if (set_cnt_q == SETTLE_LAST) begin
                    set_cnt_d = '0;
                    if (rs == '0) begin
                        col_d = col_next;
                    end else begin
                        pat_d     = rs;
                        deb_cnt_d = '0;
                        state_d   = DEBOUNCE;
                    end
                end else begin
                    set_cnt_d = set_cnt_q + 1'b1;
                end
            end
            DEBOUNCE: begin
                if (rs == pat_q) begin
                    if (deb_cnt_q == DEB_LAST) begin
                        deb_cnt_d   = '0;
                        key_valid_d = 1'b1;
                        key_index_d = rep_index;
                        key_code_d  = rep_code;
                        key_err_d   = rep_err;
                        state_d     = REPORT;
                    end else begin
                        deb_cnt_d = deb_cnt_q + 1'b1;
                    end
                end else begin
                    deb_cnt_d = '0;
                    set_cnt_d = '0;
                    state_d   = SCAN;
                end
            end
            REPORT: begin
                // Rows are ignored here so a quick release cannot cancel a pending report.
                if (key_ready) begin
                    key_valid_d = 1'b0;
                    deb_cnt_d   = '0;
                    state_d     = RELEASE;
                end
            end
            RELEASE: begin
                if (rs != '0) begin
                    deb_cnt_d = '0;
                end else if (deb_cnt_q == DEB_LAST) begin
                    deb_cnt_d = '0;
                    set_cnt_d = '0;
                    col_d     = col_next;
                    state_d   = SCAN;
                end else begin
                    deb_cnt_d = deb_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = SCAN;
            end
        endcase
    end

    always_ff @(posedge stimulus) begin
        if (reset) begin
            state_q     <= SCAN;
            col_q       <= '0;
            set_cnt_q   <= '0;
            deb_cnt_q   <= '0;
            pat_q       <= '0;
            key_valid_q <= 1'b0;
            key_index_q <= '0;
            key_code_q  <= KEY_ERR;
            key_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            set_cnt_q   <= set_cnt_d;
            deb_cnt_q   <= deb_cnt_d;
            pat_q       <= pat_d;
            key_valid_q <= key_valid_d;
            key_index_q <= key_index_d;
            key_code_q  <= key_code_d;
            key_err_q   <= key_err_d;
        end
    end

    assign col_drive = COLS'(1) << col_q;
    assign key_valid = key_valid_q;
    assign key_index = key_index_q;
    assign key_code  = key_code_q;
    assign key_err   = key_err_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// tb/tb_keypad_scan_ctrl.sv - directed bench for keypad_scan_ctrl with a behavioural key matrix
module tb_keypad_scan_ctrl;

    localparam int ROWS  = 4;
    localparam int COLS  = 3;
    localparam int SETTLE = 4;
    localparam int DEB   = 4;
    localparam int IDX_W = 6;

    logic             stimulus = 1'b0;
    logic             reset = 1'b1;
    logic [ROWS-1:0]  row_in;
    logic [COLS-1:0]  col_drive;
    logic             key_valid;
    logic             key_ready = 1'b0;
    logic [IDX_W-1:0] key_index;
    logic [3:0]       key_code;
    logic             key_err;

    logic [ROWS*COLS-1:0] pressed = '0;
    int n_pass  = 0;
    int n_total = 0;

    keypad_scan_ctrl #(
        .ROWS(ROWS), .COLS(COLS), .SETTLE_CYCLES(SETTLE),
        .DEBOUNCE_CYCLES(DEB), .IDX_W(IDX_W)
    ) dut (
        .stimulus  (stimulus),
        .reset     (reset),
        .row_in    (row_in),
        .col_drive (col_drive),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .key_index (key_index),
        .key_code  (key_code),
        .key_err   (key_err)
    );

    always #5 stimulus = ~stimulus;

    // Switch matrix: a pressed key connects its column strobe to its row line.
    always_comb begin
        row_in = '0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (pressed[r*COLS+c] && col_drive[c]) row_in[r] = 1'b1;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge stimulus);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
    endtask

    task automatic wait_valid(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            if (key_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick(1);
        end
    endtask

    task automatic test_reset();
        pressed = '0;
        key_ready = 1'b0;
        do_reset();
        n_total++; if (col_drive !== 3'b001) $display("FAIL reset_col: got %b want 001", col_drive); else n_pass++;
        n_total++; if (key_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", key_valid); else n_pass++;
        n_total++; if (key_index !== 6'd0) $display("FAIL reset_index: got %0d want 0", key_index); else n_pass++;
        n_total++; if (key_code !== 4'b1111) $display("FAIL reset_code: got %b want 1111", key_code); else n_pass++;
        n_total++; if (key_err !== 1'b0) $display("FAIL reset_err: got %b want 0", key_err); else n_pass++;
    endtask

    task automatic test_scan_idle();
        logic [COLS-1:0] exp_col;
        bit seen = 1'b0;
        pressed = '0;
        do_reset();
        for (int i = 0; i < 13; i++) begin
            exp_col = 3'(1 << ((i / SETTLE) % COLS));
            n_total++;
            if (col_drive !== exp_col) $display("FAIL scan_col[%0d]: got %b want %b", i, col_drive, exp_col);
            else n_pass++;
            if (key_valid !== 1'b0) seen = 1'b1;
            tick(1);
        end
        n_total++; if (seen) $display("FAIL scan_no_valid: got valid=1 want 0"); else n_pass++;
    endtask

    task automatic test_press_basic();
        int first = -1;
        int pulses = 0;
        logic [IDX_W-1:0] idx = '0;
        logic [3:0] code = '0;
        logic err = 1'b1;
        key_ready = 1'b1;
        pressed = '0;
        do_reset();
        pressed[1*COLS+2] = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if (key_valid === 1'b1) begin
                pulses++;
                if (first < 0) begin
                    first = i;
                    idx = key_index;
                    code = key_code;
                    err = key_err;
                end
            end
            tick(1);
        end
        // Column 2 is sampled on cycle 11 after reset; valid follows DEB+1 cycles later.
        n_total++; if (first != 11 + DEB + 1) $display("FAIL basic_latency: got %0d want %0d", first, 11 + DEB + 1); else n_pass++;
        n_total++; if (pulses != 1) $display("FAIL basic_pulses: got %0d want 1", pulses); else n_pass++;
        n_total++; if (idx !== 6'd5) $display("FAIL basic_index: got %0d want 5", idx); else n_pass++;
        n_total++; if (code !== 4'b0110) $display("FAIL basic_code: got %b want 0110", code); else n_pass++;
        n_total++; if (err !== 1'b0) $display("FAIL basic_err: got %b want 0", err); else n_pass++;
        pressed = '0;
    endtask

    task automatic test_hold_no_ready();
        bit ok;
        bit stable = 1'b1;
        int reports = 0;
        key_ready = 1'b0;
        pressed = '0;
        do_reset();
        pressed[3*COLS+0] = 1'b1;
        wait_valid(100, ok);
        n_total++; if (!ok) $display("FAIL hold_timeout: got no valid want valid"); else n_pass++;
        for (int i = 0; i < 20; i++) begin
            if (i == 10) pressed = '0;
            if (key_valid !== 1'b1 || key_code !== 4'b1010 || key_index !== 6'd9) stable = 1'b0;
            tick(1);
        end
        n_total++; if (!stable) $display("FAIL hold_stable: got code=%b valid=%b want 1010/1", key_code, key_valid); else n_pass++;
        key_ready = 1'b1;
        tick(1);
        n_total++; if (key_valid !== 1'b0) $display("FAIL hold_drop: got %b want 0", key_valid); else n_pass++;
        for (int i = 0; i < 40; i++) begin
            if (key_valid === 1'b1) reports++;
            tick(1);
        end
        n_total++; if (reports != 0) $display("FAIL hold_second: got %0d want 0", reports); else n_pass++;
    endtask

    task automatic test_bounce();
        bit ok;
        bit seen = 1'b0;
        key_ready = 1'b1;
        pressed = '0;
        do_reset();
        for (int i = 0; i < 32; i++) begin
            pressed[0*COLS+1] = ((i / 2) % 2) == 0;
            if (key_valid === 1'b1) seen = 1'b1;
            tick(1);
        end
        n_total++; if (seen) $display("FAIL bounce_early: got valid=1 want 0"); else n_pass++;
        pressed[0*COLS+1] = 1'b1;
        wait_valid(100, ok);
        n_total++; if (!ok) $display("FAIL bounce_timeout: got no valid want valid"); else n_pass++;
        n_total++; if (key_code !== 4'b0010) $display("FAIL bounce_code: got %b want 0010", key_code); else n_pass++;
        n_total++; if (key_index !== 6'd1) $display("FAIL bounce_index: got %0d want 1", key_index); else n_pass++;
        tick(1);
        pressed = '0;
    endtask

    task automatic test_multi_row();
        bit ok;
        key_ready = 1'b1;
        pressed = '0;
        do_reset();
        pressed[0*COLS+0] = 1'b1;
        pressed[2*COLS+0] = 1'b1;
        wait_valid(100, ok);
        n_total++; if (!ok) $display("FAIL multi_timeout: got no valid want valid"); else n_pass++;
        n_total++; if (key_code !== 4'b1111) $display("FAIL multi_code: got %b want 1111", key_code); else n_pass++;
        n_total++; if (key_err !== 1'b1) $display("FAIL multi_err: got %b want 1", key_err); else n_pass++;
        n_total++; if (key_index !== 6'd0) $display("FAIL multi_index: got %0d want 0", key_index); else n_pass++;
        tick(1);
        pressed = '0;
    endtask

    task automatic test_two_columns();
        int reports = 0;
        logic [3:0] code = '0;
        key_ready = 1'b1;
        pressed = '0;
        do_reset();
        pressed[0*COLS+0] = 1'b1;
        pressed[1*COLS+2] = 1'b1;
        for (int i = 0; i < 80; i++) begin
            if (key_valid === 1'b1) begin
                reports++;
                code = key_code;
            end
            tick(1);
        end
        n_total++; if (reports != 1) $display("FAIL twocol_reports: got %0d want 1", reports); else n_pass++;
        n_total++; if (code !== 4'b0001) $display("FAIL twocol_code: got %b want 0001", code); else n_pass++;
        pressed = '0;
    endtask

    task automatic test_reset_mid();
        bit ok;
        key_ready = 1'b0;
        pressed = '0;
        do_reset();
        pressed[2*COLS+1] = 1'b1;
        wait_valid(100, ok);
        n_total++; if (!ok) $display("FAIL mid_timeout1: got no valid want valid"); else n_pass++;
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        n_total++; if (key_valid !== 1'b0) $display("FAIL mid_valid: got %b want 0", key_valid); else n_pass++;
        n_total++; if (col_drive !== 3'b001) $display("FAIL mid_col: got %b want 001", col_drive); else n_pass++;
        n_total++; if (key_code !== 4'b1111) $display("FAIL mid_code: got %b want 1111", key_code); else n_pass++;
        wait_valid(100, ok);
        n_total++; if (!ok) $display("FAIL mid_timeout2: got no valid want valid"); else n_pass++;
        n_total++; if (key_code !== 4'b1000) $display("FAIL mid_recode: got %b want 1000", key_code); else n_pass++;
        n_total++; if (key_index !== 6'd7) $display("FAIL mid_reindex: got %0d want 7", key_index); else n_pass++;
        key_ready = 1'b1;
        tick(1);
        pressed = '0;
    endtask

    initial begin
        test_reset();
        test_scan_idle();
        test_press_basic();
        test_hold_no_ready();
        test_bounce();
        test_multi_row();
        test_two_columns();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

endmodule
